// File: rtl/cpu_if_pkg.sv
// cpu_if_pkg: shared constants for the CPU register bank.
//   Address map (byte addresses, word aligned), mode command codes,
//   access FSM state encodings and the core test register reset pattern.
package cpu_if_pkg;

  localparam logic [31:0] A_PORT      = 32'h0000_4000;
  localparam logic [31:0] A_MODE      = 32'h0000_4004;
  localparam logic [31:0] A_CNT_BASE  = 32'h0000_4100;
  localparam logic [31:0] A_TEST_BASE = 32'h0000_8000;
  localparam logic [31:0] A_STAT      = 32'h0000_8100;
  localparam logic [31:0] A_ERR       = 32'h0000_8200;

  localparam logic [7:0] MODE_ON  = 8'h55;
  localparam logic [7:0] MODE_OFF = 8'hAA;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPT = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Test reg i resets to TEST_RST[i % 4], truncated to the register width.
  localparam logic [3:0][31:0] TEST_RST = {32'hA5A5_A5A5, 32'h5A5A_5A5A,
                                           32'hFFFF_FFFF, 32'h0000_0000};

endpackage

// File: rtl/cpu_if_regbank_if.sv
// cpu_if_regbank_if: board CPU bus.
//   master: drives strobes (cs/rd/we, active low), addr, wdata.
//   slave : drives rdata, rdata_oe_n, rdy_n (active low).
interface cpu_if_regbank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_cs_n;
  logic              cpu_rd_n;
  logic              cpu_we_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_oe_n;
  logic              cpu_rdy_n;

  modport master (output cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_rdata_oe_n, cpu_rdy_n);
  modport slave  (input  cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_rdata_oe_n, cpu_rdy_n);
endinterface

// File: rtl/cpu_if_evt_cnt.sv
// cpu_if_evt_cnt: one event counter.
//   clk_i/rst_i : clock, sync active-high reset
//   evt_i       : async event level; each rising edge counts once
//   clr_i       : clear-on-read strobe
//   cnt_o       : saturating count
module cpu_if_evt_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync_q[1] & ~prev_q;

  // An edge landing in the clear cycle is not lost: it becomes the first count.
  always_comb begin
    cnt_d = cnt_q;
    if (rise)       cnt_d = clr_i ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    else if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], evt_i};
      prev_q <= sync_q[1];
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_if_regbank.sv
// cpu_if_regbank: synchronous CPU register bank.
//   clk_50m, rst_core     : clock, sync active-high reset
//   bus (slave)           : async CPU bus, resynchronised; RDY handshake
//   evt_in                : event levels feeding NUM_CNT clear-on-read counters
//   core_busy/a_err/d_err : core status
//   port_sel, mode        : control outputs
//   test_start, test_end  : one-cycle pulses after a mode write commits
//   test_regs             : reg i at [i*TEST_W +: TEST_W]
module cpu_if_regbank
  import cpu_if_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NUM_TEST = 16,
  parameter int TEST_W   = 24,
  parameter int NUM_CNT  = 5,
  parameter int CNT_W    = 32,
  parameter int SYNC_STG = 2
) (
  input  logic                       clk_50m,
  input  logic                       rst_core,
  cpu_if_regbank_if.slave            bus,
  input  logic [NUM_CNT-1:0]         evt_in,
  input  logic                       core_busy,
  input  logic                       core_a_err,
  input  logic                       core_d_err,
  output logic                       port_sel,
  output logic                       mode,
  output logic                       test_start,
  output logic                       test_end,
  output logic [NUM_TEST*TEST_W-1:0] test_regs
);
  localparam int WA_W = ADDR_W - 2;

  logic [SYNC_STG-1:0] cs_sq, rd_sq, we_sq;
  logic cs_s, rd_s, we_s;
  logic [2:0] state_q, state_d;
  logic [WA_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rd_mux;
  logic wr_q, wr_d, oe_n_q, oe_n_d, rdy_n_q, rdy_n_d;
  logic port_sel_q, port_sel_d, mode_q, mode_d;
  logic start_q, start_d, end_q, end_d;
  logic [NUM_TEST-1:0][TEST_W-1:0] test_q, test_d;
  logic [3:0] err_q, err_d, err_set, err_clr;
  logic a_prev_q, d_prev_q, a_rise, d_rise;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_v;
  logic [NUM_CNT-1:0] clr_v;
  logic [5:0] idx;
  logic hit_port, hit_mode, hit_stat, hit_err, win_cnt, win_test, hit_test;
  logic need_wait, exec_wr, exec_rd;
  logic unused_addr;

  assign unused_addr = ^bus.cpu_addr[1:0];
  assign cs_s = cs_sq[SYNC_STG-1];
  assign rd_s = rd_sq[SYNC_STG-1];
  assign we_s = we_sq[SYNC_STG-1];

  // Decode works on the latched word address.
  assign idx      = waddr_q[5:0];
  assign hit_port = waddr_q == A_PORT[ADDR_W-1:2];
  assign hit_mode = waddr_q == A_MODE[ADDR_W-1:2];
  assign hit_stat = waddr_q == A_STAT[ADDR_W-1:2];
  assign hit_err  = waddr_q == A_ERR[ADDR_W-1:2];
  assign win_cnt  = waddr_q[WA_W-1:6] == A_CNT_BASE[ADDR_W-1:8];
  assign win_test = waddr_q[WA_W-1:6] == A_TEST_BASE[ADDR_W-1:8];
  assign hit_test = win_test && (int'(idx) < NUM_TEST);

  // Port changes and test reg writes in test mode must not race a busy core.
  assign need_wait = core_busy && (hit_port || (hit_test && mode_q));
  assign exec_wr   = (state_q == S_EXEC) && wr_q;
  assign exec_rd   = (state_q == S_EXEC) && !wr_q;

  assign a_rise  = core_a_err & ~a_prev_q;
  assign d_rise  = core_d_err & ~d_prev_q;
  assign err_set = !mode_q ? 4'b0 :
                   port_sel_q ? {d_rise, a_rise, 2'b00} : {2'b00, d_rise, a_rise};
  assign err_clr = (exec_wr && hit_err) ? wdata_q[3:0] : 4'b0;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign clr_v[g] = exec_rd && win_cnt && (idx == 6'(g));
    cpu_if_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i(clk_50m), .rst_i(rst_core), .evt_i(evt_in[g]),
      .clr_i(clr_v[g]), .cnt_o(cnt_v[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (hit_port) rd_mux = DATA_W'(port_sel_q);
    if (hit_mode) rd_mux = DATA_W'(mode_q);
    if (hit_stat) rd_mux = DATA_W'({port_sel_q, mode_q, core_busy, core_a_err, core_d_err});
    if (hit_err)  rd_mux = DATA_W'(err_q);
    for (int i = 0; i < NUM_CNT; i++)
      if (win_cnt && idx == 6'(i)) rd_mux = DATA_W'(cnt_v[i]);
    for (int i = 0; i < NUM_TEST; i++)
      if (win_test && idx == 6'(i)) rd_mux = DATA_W'(test_q[i]);
  end

  always_comb begin
    state_d = state_q; waddr_d = waddr_q; wdata_d = wdata_q; wr_d = wr_q;
    rdata_d = rdata_q; oe_n_d = oe_n_q; rdy_n_d = rdy_n_q;
    port_sel_d = port_sel_q; mode_d = mode_q; start_d = 1'b0; end_d = 1'b0;
    test_d = test_q;
    err_d  = (err_q & ~err_clr) | err_set;  // set wins
    case (state_q)
      S_IDLE: if (!cs_s && (!rd_s || !we_s)) begin
        state_d = S_CAPT;
        waddr_d = bus.cpu_addr[ADDR_W-1:2];
        wdata_d = bus.cpu_wdata;
        wr_d    = !we_s;  // write wins if both strobes are low
      end
      S_CAPT: state_d = (wr_q && need_wait) ? S_WAIT : S_EXEC;
      S_WAIT: if (!core_busy) state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_DONE;
        rdy_n_d = 1'b0;
        if (!wr_q) begin
          rdata_d = rd_mux;
          oe_n_d  = 1'b0;
        end else begin
          if (hit_port) port_sel_d = wdata_q[0];
          if (hit_mode && wdata_q == DATA_W'(MODE_ON)) begin
            mode_d = 1'b1; start_d = !mode_q; end_d = 1'b1;
          end
          if (hit_mode && wdata_q == DATA_W'(MODE_OFF)) begin
            mode_d = 1'b0; end_d = 1'b1;
          end
          for (int i = 0; i < NUM_TEST; i++)
            if (win_test && idx == 6'(i)) test_d[i] = wdata_q[TEST_W-1:0];
        end
      end
      S_DONE: if (cs_s) begin
        state_d = S_IDLE; rdy_n_d = 1'b1; oe_n_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst_core) begin
      cs_sq <= '1; rd_sq <= '1; we_sq <= '1;
      state_q <= S_IDLE; waddr_q <= '0; wdata_q <= '0; wr_q <= 1'b0;
      rdata_q <= '0; oe_n_q <= 1'b1; rdy_n_q <= 1'b1;
      port_sel_q <= 1'b0; mode_q <= 1'b0; start_q <= 1'b0; end_q <= 1'b0;
      err_q <= '0; a_prev_q <= 1'b0; d_prev_q <= 1'b0;
      for (int i = 0; i < NUM_TEST; i++) test_q[i] <= TEST_W'(TEST_RST[i[1:0]]);
    end else begin
      cs_sq <= {cs_sq[SYNC_STG-2:0], bus.cpu_cs_n};
      rd_sq <= {rd_sq[SYNC_STG-2:0], bus.cpu_rd_n};
      we_sq <= {we_sq[SYNC_STG-2:0], bus.cpu_we_n};
      state_q <= state_d; waddr_q <= waddr_d; wdata_q <= wdata_d; wr_q <= wr_d;
      rdata_q <= rdata_d; oe_n_q <= oe_n_d; rdy_n_q <= rdy_n_d;
      port_sel_q <= port_sel_d; mode_q <= mode_d; start_q <= start_d; end_q <= end_d;
      err_q <= err_d; a_prev_q <= core_a_err; d_prev_q <= core_d_err;
      test_q <= test_d;
    end
  end

  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_rdata_oe_n = oe_n_q;
  assign bus.cpu_rdy_n      = rdy_n_q;
  assign port_sel   = port_sel_q;
  assign mode       = mode_q;
  assign test_start = start_q;
  assign test_end   = end_q;
  assign test_regs  = test_q;
endmodule

// File: tb/tb_cpu_if_regbank.sv
module tb_cpu_if_regbank;
  import cpu_if_pkg::*;

  logic clk_50m = 1'b0;
  logic rst_core;
  logic [4:0] evt_in;
  logic core_busy, core_a_err, core_d_err;
  logic port_sel, mode, test_start, test_end;
  logic [16*24-1:0] test_regs;
  int n_tests = 0, n_fail = 0;
  int ts_cnt = 0, te_cnt = 0;
  logic [31:0] rd;
  int n;
  bit ok;

  cpu_if_regbank_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  cpu_if_regbank dut (
    .clk_50m(clk_50m), .rst_core(rst_core), .bus(bus.slave), .evt_in(evt_in),
    .core_busy(core_busy), .core_a_err(core_a_err), .core_d_err(core_d_err),
    .port_sel(port_sel), .mode(mode), .test_start(test_start), .test_end(test_end),
    .test_regs(test_regs)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (test_start) ts_cnt++;
    if (test_end)   te_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus_start(input logic [15:0] a, input logic [31:0] d, input bit wr);
    @(posedge clk_50m); #1;
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_cs_n = 1'b0;
    if (wr) bus.cpu_we_n = 1'b0; else bus.cpu_rd_n = 1'b0;
  endtask

  task automatic wait_rdy(input int max, output int cnt, output bit got);
    cnt = 0; got = 1'b0;
    while (cnt < max && !got) begin
      @(posedge clk_50m); #1;
      cnt++;
      if (!bus.cpu_rdy_n) got = 1'b1;
    end
  endtask

  task automatic bus_end();
    int k = 0;
    bus.cpu_cs_n = 1'b1; bus.cpu_rd_n = 1'b1; bus.cpu_we_n = 1'b1;
    while (bus.cpu_rdy_n === 1'b0 && k < 20) begin @(posedge clk_50m); #1; k++; end
    chk("rdy_release", bus.cpu_rdy_n, 1);
    repeat (2) @(posedge clk_50m);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [31:0] d);
    int c; bit g;
    bus_start(a, d, 1'b1);
    wait_rdy(40, c, g);
    chk("wr_rdy", g, 1);
    chk("wr_oe", bus.cpu_rdata_oe_n, 1);
    bus_end();
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [31:0] d);
    int c; bit g;
    bus_start(a, 32'h0, 1'b0);
    wait_rdy(40, c, g);
    chk("rd_rdy", g, 1);
    chk("rd_oe", bus.cpu_rdata_oe_n, 0);
    d = bus.cpu_rdata;
    bus_end();
  endtask

  task automatic evt_pulses(input int i, input int k);
    for (int p = 0; p < k; p++) begin
      @(posedge clk_50m); #1 evt_in[i] = 1'b1;
      repeat (3) @(posedge clk_50m);
      #1 evt_in[i] = 1'b0;
      repeat (3) @(posedge clk_50m);
    end
    repeat (4) @(posedge clk_50m);
  endtask

  initial begin
    rst_core = 1'b1; evt_in = '0; core_busy = 0; core_a_err = 0; core_d_err = 0;
    bus.cpu_cs_n = 1; bus.cpu_rd_n = 1; bus.cpu_we_n = 1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (4) @(posedge clk_50m);
    #1 rst_core = 1'b0;

    // 1: reset state, first read and its latency
    chk("rst_rdy", bus.cpu_rdy_n, 1);
    chk("rst_oe", bus.cpu_rdata_oe_n, 1);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_port", port_sel, 0);
    chk("rst_mode", mode, 0);
    chk("rst_treg2", test_regs[2*24 +: 24], 24'h5A5A5A);
    bus_start(16'h8004, 0, 1'b0);
    wait_rdy(20, n, ok);
    chk("lat", n, 5);
    chk("lat_oe", bus.cpu_rdata_oe_n, 0);
    chk("rd_8004", bus.cpu_rdata, 32'h00FF_FFFF);
    bus_end();

    // 2: mode writes and pulses
    ts_cnt = 0; te_cnt = 0;
    cpu_wr(16'h4004, 32'h55);
    chk("mode_on", mode, 1); chk("ts_on", ts_cnt, 1); chk("te_on", te_cnt, 1);
    ts_cnt = 0; te_cnt = 0;
    cpu_wr(16'h4004, 32'hAA);
    chk("mode_off", mode, 0); chk("ts_off", ts_cnt, 0); chk("te_off", te_cnt, 1);
    ts_cnt = 0; te_cnt = 0;
    cpu_wr(16'h4004, 32'h12);
    chk("mode_x", mode, 0); chk("ts_x", ts_cnt, 0); chk("te_x", te_cnt, 0);

    // 3: test reg write held off by busy core
    cpu_wr(16'h4004, 32'h55);
    core_busy = 1'b1;
    bus_start(16'h8010, 32'h0012_3456, 1'b1);
    wait_rdy(12, n, ok);
    chk("busy_rdy", bus.cpu_rdy_n, 1);
    chk("busy_treg4", test_regs[4*24 +: 24], 24'h0);
    core_busy = 1'b0;
    wait_rdy(10, n, ok);
    chk("unbusy_lat", n, 2);
    chk("unbusy_treg4", test_regs[4*24 +: 24], 24'h123456);
    bus_end();

    // 4: counters
    evt_pulses(2, 7);
    cpu_rd(16'h4108, rd); chk("cnt2_7", rd, 7);
    cpu_rd(16'h4108, rd); chk("cnt2_clr", rd, 0);
    @(posedge clk_50m); #1 force dut.g_cnt[2].u_cnt.cnt_q = 32'hFFFF_FFFE;
    @(posedge clk_50m); #1 release dut.g_cnt[2].u_cnt.cnt_q;
    evt_pulses(2, 3);
    cpu_rd(16'h4108, rd); chk("cnt2_sat", rd, 32'hFFFF_FFFF);
    bus_start(16'h4108, 0, 1'b0);
    repeat (2) @(posedge clk_50m);
    #1 evt_in[2] = 1'b1;
    wait_rdy(20, n, ok);
    chk("cnt2_coin_rd", bus.cpu_rdata, 0);
    bus_end();
    evt_in[2] = 1'b0;
    repeat (4) @(posedge clk_50m);
    cpu_rd(16'h4108, rd); chk("cnt2_coin", rd, 1);
    cpu_rd(16'h4100, rd); chk("cnt0", rd, 0);
    cpu_rd(16'h4114, rd); chk("cnt_oor", rd, 0);
    cpu_rd(16'h9000, rd); chk("unmapped", rd, 0);

    // 5: sticky error flags
    cpu_wr(16'h4000, 32'h1);
    chk("port_b", port_sel, 1);
    cpu_rd(16'h8100, rd); chk("stat", rd, 32'h18);
    @(posedge clk_50m); #1 core_a_err = 1'b1;
    repeat (3) @(posedge clk_50m);
    cpu_rd(16'h8200, rd); chk("err_set", rd, 4);
    #1 core_a_err = 1'b0;
    repeat (3) @(posedge clk_50m);
    bus_start(16'h8200, 32'h4, 1'b1);
    repeat (4) @(posedge clk_50m);
    #1 core_a_err = 1'b1;
    wait_rdy(20, n, ok);
    bus_end();
    cpu_rd(16'h8200, rd); chk("err_setwins", rd, 4);
    #1 core_a_err = 1'b0;
    repeat (3) @(posedge clk_50m);
    cpu_wr(16'h8200, 32'h4);
    cpu_rd(16'h8200, rd); chk("err_w1c", rd, 0);

    // 6: reset during WAIT
    core_busy = 1'b1;
    bus_start(16'h8008, 32'h00DE_AD00, 1'b1);
    wait_rdy(10, n, ok);
    chk("wait6_rdy", bus.cpu_rdy_n, 1);
    @(posedge clk_50m); #1 rst_core = 1'b1;
    bus.cpu_cs_n = 1; bus.cpu_we_n = 1;
    repeat (3) @(posedge clk_50m);
    #1 rst_core = 1'b0; core_busy = 1'b0;
    chk("rst6_rdy", bus.cpu_rdy_n, 1);
    chk("rst6_oe", bus.cpu_rdata_oe_n, 1);
    chk("rst6_treg2", test_regs[2*24 +: 24], 24'h5A5A5A);
    chk("rst6_state", dut.state_q, S_IDLE);
    repeat (6) @(posedge clk_50m);
    #1 chk("rst6_treg2_late", test_regs[2*24 +: 24], 24'h5A5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
